// File: rtl/animation_sequencer.sv
// ============================================================================
// animation_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Frame/animation sequencer for the 7-segment animation engine.
//   - The prescaler divides clk into frame steps (one step every DIV cycles).
//   - Each step advances the frame index through 0..L-1, where L is the
//     current animation's frame count (0 on the limit input is treated as 1).
//   - The active animation comes either from ani_sel (manual mode) or is
//     auto-advanced after LOOPS complete loops, or at once on next_req.
//
// Configuration macro:
//   RANDOM_ORDER_EN - when defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4,
//                     seed 8'hA5) picks the next animation in auto mode.
//                     When undefined the order is strictly sequential.
//
// Parameters:
//   DIV      clk cycles per frame step (>= 2)
//   DIV_W    prescaler width (must hold DIV-1)
//   NUM_ANI  number of valid animations (<= 64)
//   LOOPS    complete loops per animation before auto-advance (>= 1)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   auto_mode  in   1: auto-advance, 0: animation follows ani_sel
//   pause      in   1: freeze prescaler and frame
//   next_req   in   auto mode only: jump to the next animation now
//   ani_sel    in   [5:0] manual animation index
//   limit      in   [5:0] frame count of the current animation (lookup)
//   animation  out  [5:0] registered active animation index
//   frame      out  [5:0] registered frame index
//   frame_stb  out  1-cycle pulse while animation/frame show a new value
//   loop_done  out  1-cycle pulse while frame shows a step-wrap to 0
// ============================================================================
module animation_sequencer #(
    parameter int unsigned DIV     = 5000000,
    parameter int unsigned DIV_W   = 23,
    parameter int unsigned NUM_ANI = 61,
    parameter int unsigned LOOPS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auto_mode,
    input  logic       pause,
    input  logic       next_req,
    input  logic [5:0] ani_sel,
    input  logic [5:0] limit,
    output logic [5:0] animation,
    output logic [5:0] frame,
    output logic       frame_stb,
    output logic       loop_done
);

    localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    localparam logic [DIV_W-1:0]  PRESC_MAX = DIV_W'(DIV - 1);
    localparam logic [5:0]        LAST_ANI  = 6'(NUM_ANI - 1);
    localparam logic [6:0]        NUM_ANI_7 = 7'(NUM_ANI);
    localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0]  presc_q,     presc_d;
    logic [5:0]        animation_q, animation_d;
    logic [5:0]        frame_q,     frame_d;
    logic [LOOP_W-1:0] loop_q,      loop_d;
    logic              frame_stb_q, frame_stb_d;
    logic              loop_done_q, loop_done_d;

    // ------------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------------
    logic [5:0] eff_limit;
    logic [5:0] last_frame;
    logic       step;
    logic       wrap;
    logic [5:0] target;
    logic [5:0] seq_next;
    logic [5:0] next_ani;

    always_comb begin
        eff_limit  = (limit == 6'd0) ? 6'd1 : limit;
        last_frame = eff_limit - 6'd1;
        step       = !pause && (presc_q == PRESC_MAX);
        // >= rather than == so a limit that shrinks below the current frame
        // still wraps on the next step instead of running up to 63.
        wrap       = step && (frame_q >= last_frame);
        // 7-bit compare keeps NUM_ANI = 64 from aliasing to zero.
        target     = ({1'b0, ani_sel} >= NUM_ANI_7) ? 6'd0 : ani_sel;
        seq_next   = (animation_q == LAST_ANI) ? 6'd0 : animation_q + 6'd1;
    end

`ifdef RANDOM_ORDER_EN
    // ------------------------------------------------------------------------
    // Random order: free-running LFSR, candidate taken only if it is a valid
    // index and differs from the current animation.
    // ------------------------------------------------------------------------
    logic [7:0] lfsr_q, lfsr_d;
    logic [5:0] rnd;

    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        rnd      = lfsr_q[5:0];
        next_ani = (({1'b0, rnd} < NUM_ANI_7) && (rnd != animation_q)) ? rnd : seq_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        next_ani = seq_next;
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        presc_d     = pause ? presc_q : (step ? '0 : presc_q + 1'b1);
        animation_d = animation_q;
        frame_d     = frame_q;
        loop_d      = loop_q;
        loop_done_d = 1'b0;

        if (!auto_mode) begin
            // Manual: a differing selection reloads and beats any step.
            if (target != animation_q) begin
                animation_d = target;
                frame_d     = '0;
                presc_d     = '0;
                loop_d      = '0;
            end else if (step) begin
                if (wrap) begin
                    frame_d     = '0;
                    loop_done_d = 1'b1;
                    loop_d      = (loop_q == LAST_LOOP) ? '0 : loop_q + 1'b1;
                end else begin
                    frame_d = frame_q + 6'd1;
                end
            end
        end else if (next_req) begin
            // Skip request overrides a coincident step entirely.
            animation_d = next_ani;
            frame_d     = '0;
            presc_d     = '0;
            loop_d      = '0;
        end else if (step) begin
            if (wrap) begin
                frame_d     = '0;
                loop_done_d = 1'b1;
                if (loop_q == LAST_LOOP) begin
                    animation_d = next_ani;
                    loop_d      = '0;
                end else begin
                    loop_d = loop_q + 1'b1;
                end
            end else begin
                frame_d = frame_q + 6'd1;
            end
        end

        // Strobe marks the edge on which the visible index pair changes.
        frame_stb_d = (animation_d != animation_q) || (frame_d != frame_q);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            presc_q     <= '0;
            animation_q <= '0;
            frame_q     <= '0;
            loop_q      <= '0;
            frame_stb_q <= 1'b0;
            loop_done_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            animation_q <= animation_d;
            frame_q     <= frame_d;
            loop_q      <= loop_d;
            frame_stb_q <= frame_stb_d;
            loop_done_q <= loop_done_d;
        end
    end

    assign animation = animation_q;
    assign frame     = frame_q;
    assign frame_stb = frame_stb_q;
    assign loop_done = loop_done_q;

endmodule

// File: tb/tb_animation_sequencer.sv
// ============================================================================
// tb_animation_sequencer
// Directed scenarios followed by a randomized run, all compared every cycle
// against a behavioural model of the sequencing rules (default build).
// ============================================================================
module tb_animation_sequencer;

    localparam int DIV     = 4;
    localparam int NUM_ANI = 61;
    localparam int LOOPS   = 2;

    logic       clk = 1'b0;
    logic       rst, auto_mode, pause, next_req;
    logic [5:0] ani_sel, limit, animation, frame;
    logic       frame_stb, loop_done;

    logic       use_lut;
    logic [5:0] limit_force;

    int checks = 0;
    int errors = 0;
    int stb_cnt, ld_cnt;

    // Model state
    int m_an, m_fr, m_pre, m_lc;
    bit exp_stb, exp_ld;

    always #5 clk = ~clk;

    animation_sequencer #(
        .DIV     (DIV),
        .DIV_W   (2),
        .NUM_ANI (NUM_ANI),
        .LOOPS   (LOOPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .auto_mode (auto_mode),
        .pause     (pause),
        .next_req  (next_req),
        .ani_sel   (ani_sel),
        .limit     (limit),
        .animation (animation),
        .frame     (frame),
        .frame_stb (frame_stb),
        .loop_done (loop_done)
    );

    // Stand-in for the frame-count lookup ROM (includes zero entries).
    function automatic logic [5:0] lut6(input int a);
        return 6'((a * 7 + 3) % 17);
    endfunction

    assign limit = use_lut ? lut6(int'(animation)) : limit_force;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: predict from the rules, clock, then compare every output.
    task automatic tick();
        int lim, eff, tgt;
        int n_an, n_fr, n_pre, n_lc;
        bit n_ld, stp;
        if (rst) begin
            n_an = 0; n_fr = 0; n_pre = 0; n_lc = 0; n_ld = 0;
        end else begin
            lim   = use_lut ? int'(lut6(m_an)) : int'(limit_force);
            eff   = (lim == 0) ? 1 : lim;
            stp   = !pause && (m_pre == DIV - 1);
            n_an  = m_an; n_fr = m_fr; n_lc = m_lc; n_ld = 0;
            n_pre = pause ? m_pre : (m_pre + 1) % DIV;
            if (!auto_mode) begin
                tgt = (int'(ani_sel) >= NUM_ANI) ? 0 : int'(ani_sel);
                if (tgt != m_an) begin
                    n_an = tgt; n_fr = 0; n_pre = 0; n_lc = 0;
                end else if (stp) begin
                    if (m_fr >= eff - 1) begin
                        n_fr = 0; n_ld = 1; n_lc = (m_lc + 1) % LOOPS;
                    end else begin
                        n_fr = m_fr + 1;
                    end
                end
            end else if (next_req) begin
                n_an = (m_an + 1) % NUM_ANI; n_fr = 0; n_pre = 0; n_lc = 0;
            end else if (stp) begin
                if (m_fr >= eff - 1) begin
                    n_fr = 0; n_ld = 1;
                    if (m_lc + 1 == LOOPS) begin
                        n_an = (m_an + 1) % NUM_ANI; n_lc = 0;
                    end else begin
                        n_lc = m_lc + 1;
                    end
                end else begin
                    n_fr = m_fr + 1;
                end
            end
        end
        exp_stb = !rst && ((n_an != m_an) || (n_fr != m_fr));
        exp_ld  = n_ld;
        @(posedge clk);
        #1;
        m_an = n_an; m_fr = n_fr; m_pre = n_pre; m_lc = n_lc;
        check("animation", 32'(animation), 32'(m_an));
        check("frame",     32'(frame),     32'(m_fr));
        check("frame_stb", 32'(frame_stb), 32'(exp_stb));
        check("loop_done", 32'(loop_done), 32'(exp_ld));
        stb_cnt += int'(frame_stb);
        ld_cnt  += int'(loop_done);
    endtask

    initial begin
        int n;
        int f_before;
        rst = 1'b1; auto_mode = 1'b0; pause = 1'b0; next_req = 1'b0;
        ani_sel = 6'd0; use_lut = 1'b0; limit_force = 6'd10;
        m_an = 0; m_fr = 0; m_pre = 0; m_lc = 0;
        stb_cnt = 0; ld_cnt = 0;

        // 1. Reset, then manual animation 0 with 10 frames.
        tick(); tick();
        rst = 1'b0;
        check("rst_animation", 32'(animation), 32'd0);
        check("rst_frame",     32'(frame),     32'd0);
        check("rst_stb",       32'(frame_stb), 32'd0);
        check("rst_loop_done", 32'(loop_done), 32'd0);
        stb_cnt = 0; ld_cnt = 0;
        repeat (40) tick();
        check("t1_stb_count", 32'(stb_cnt), 32'd10);
        check("t1_ld_count",  32'(ld_cnt),  32'd1);
        check("t1_frame_end", 32'(frame),   32'd0);

        // 2. Manual reload at frame 5.
        n = 0;
        while (m_fr != 5 && n < 100) begin tick(); n++; end
        check("t2_reach_f5", 32'(frame), 32'd5);
        ani_sel = 6'd16;
        tick();
        check("t2_load_ani",   32'(animation), 32'd16);
        check("t2_load_frame", 32'(frame),     32'd0);
        check("t2_load_stb",   32'(frame_stb), 32'd1);
        repeat (3) tick();
        check("t2_no_early_step", 32'(frame), 32'd0);
        tick();
        check("t2_first_step", 32'(frame), 32'd1);

        // 3. Auto mode from animation 60, limit 2: two loops then wrap to 0.
        ani_sel = 6'd60;
        tick();
        auto_mode = 1'b1; limit_force = 6'd2; ld_cnt = 0;
        repeat (16) tick();
        check("t3_ani_wrap",  32'(animation), 32'd0);
        check("t3_frame",     32'(frame),     32'd0);
        check("t3_ld_count",  32'(ld_cnt),    32'd2);

        // 4. Pause for 10 clocks with the prescaler at 2.
        auto_mode = 1'b0; ani_sel = 6'd0; limit_force = 6'd10;
        n = 0;
        while (m_pre != 2 && n < 20) begin tick(); n++; end
        f_before = m_fr;
        pause = 1'b1; stb_cnt = 0;
        repeat (10) tick();
        check("t4_pause_stb",   32'(stb_cnt), 32'd0);
        check("t4_pause_frame", 32'(frame),   32'(f_before));
        pause = 1'b0;
        repeat (4) tick();

        // 5. next_req coincident with a step at animation 7, frame 3.
        ani_sel = 6'd7;
        tick();
        auto_mode = 1'b1;
        n = 0;
        while (!(m_fr == 3 && m_pre == DIV - 1) && n < 200) begin tick(); n++; end
        check("t5_reach_f3", 32'(frame), 32'd3);
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        check("t5_ani",       32'(animation), 32'd8);
        check("t5_frame",     32'(frame),     32'd0);
        check("t5_loop_done", 32'(loop_done), 32'd0);

        // 6. Out-of-range selection, zero limit, then reset mid-run.
        auto_mode = 1'b0; ani_sel = 6'd62;
        tick();
        check("t6_sel_clamp", 32'(animation), 32'd0);
        limit_force = 6'd0; ld_cnt = 0;
        repeat (20) tick();
        check("t6_ld_count", 32'(ld_cnt), 32'd5);
        check("t6_frame0",   32'(frame),  32'd0);
        limit_force = 6'd10;
        n = 0;
        while (m_fr != 4 && n < 100) begin tick(); n++; end
        check("t6_reach_f4", 32'(frame), 32'd4);
        rst = 1'b1;
        tick();
        check("t6_rst_frame", 32'(frame),     32'd0);
        check("t6_rst_ani",   32'(animation), 32'd0);
        rst = 1'b0;

        // Randomized run with the lookup feeding limit.
        use_lut = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            next_req = ($urandom_range(0, 19) == 0);
            pause    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 29) == 0) ani_sel = 6'($urandom_range(0, 63));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
